// File: rtl/alu_issue_ctrl.sv
// Command sequencer for the ALU: register-file operand fetch, ALU issue, write-back and response.
// Optional macro ALU_ISSUE_IMM_EN: cmd_bsel selects cmd_data as the b operand.
module alu_issue_ctrl #(
   parameter int unsigned NREG = 16,
   parameter int unsigned DW   = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [3:0]    cmd_op,
   input  logic          cmd_ld,
   input  logic          cmd_bsel,
   input  logic [3:0]    cmd_rd,
   input  logic [3:0]    cmd_rn,
   input  logic [3:0]    cmd_rm,
   input  logic [DW-1:0] cmd_data,
   output logic [3:0]    alu_op,
   output logic [DW-1:0] alu_a,
   output logic [DW-1:0] alu_b,
   input  logic [DW-1:0] alu_out,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_data,
   output logic          rsp_err,
   input  logic [3:0]    dbg_addr,
   output logic [DW-1:0] dbg_data
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t        state;
   logic [DW-1:0] regs [NREG];
   logic [3:0]    rd_q;
   logic          ld_q;
   logic [DW-1:0] data_q;

`ifndef ALU_ISSUE_IMM_EN
   logic unused_bsel;
   assign unused_bsel = cmd_bsel;
`endif

   // Valid ALU opcodes: 0000-0100 and 0110-1011.
   function automatic logic op_valid(input logic [3:0] op);
      return (op <= 4'd11) && (op != 4'd5);
   endfunction

   assign cmd_ready = (state == IDLE);
   assign dbg_data  = regs[dbg_addr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
         rd_q      <= '0;
         ld_q      <= 1'b0;
         data_q    <= '0;
         alu_op    <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  alu_op <= cmd_op;
                  alu_a  <= regs[cmd_rn];
`ifdef ALU_ISSUE_IMM_EN
                  alu_b  <= cmd_bsel ? cmd_data : regs[cmd_rm];
`else
                  alu_b  <= regs[cmd_rm];
`endif
                  rd_q   <= cmd_rd;
                  ld_q   <= cmd_ld;
                  data_q <= cmd_data;
                  state  <= EXEC;
               end
            end
            EXEC: begin
               if (ld_q) begin
                  regs[rd_q] <= data_q;
                  rsp_data   <= data_q;
                  rsp_err    <= 1'b0;
               end else if (op_valid(alu_op)) begin
                  regs[rd_q] <= alu_out;
                  rsp_data   <= alu_out;
                  rsp_err    <= 1'b0;
               end else begin
                  rsp_data   <= '0;
                  rsp_err    <= 1'b1;
               end
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU; expectations adapt to ALU_ISSUE_IMM_EN.
module tb_alu_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_ld, cmd_bsel;
   logic [3:0]  cmd_op, cmd_rd, cmd_rn, cmd_rm;
   logic [31:0] cmd_data;
   logic [3:0]  alu_op;
   logic [31:0] alu_a, alu_b, alu_out;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_data;
   logic [3:0]  dbg_addr;
   logic [31:0] dbg_data;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_issue_ctrl dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_ld(cmd_ld),
      .cmd_bsel(cmd_bsel), .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm),
      .cmd_data(cmd_data), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_out(alu_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_err(rsp_err), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   // Behavioural ALU; invalid opcodes return a marker that must never reach rsp_data.
   always_comb begin
      case (alu_op)
         4'd0:    alu_out = alu_a + alu_b;
         4'd1:    alu_out = alu_a - alu_b;
         4'd2:    alu_out = alu_a & alu_b;
         4'd3:    alu_out = alu_a | alu_b;
         4'd4:    alu_out = alu_a ^ alu_b;
         4'd6:    alu_out = alu_a;
         4'd7:    alu_out = alu_b;
         4'd8:    alu_out = alu_a << alu_b;
         4'd9:    alu_out = alu_a >> alu_b;
         4'd10:   alu_out = 32'($signed(alu_a) >>> alu_b);
         4'd11:   alu_out = ~alu_a;
         default: alu_out = 32'hDEAD_BEEF;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Called 1 time unit after a rising edge with the DUT idle.
   task automatic issue(input string tag, input logic [3:0] op, input logic ld, input logic bsel,
                        input logic [3:0] rd, input logic [3:0] rn, input logic [3:0] rm,
                        input logic [31:0] data, input logic [31:0] exp_data, input logic exp_err);
      cmd_op = op; cmd_ld = ld; cmd_bsel = bsel; cmd_rd = rd; cmd_rn = rn; cmd_rm = rm;
      cmd_data = data; cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      chk({tag, "_exec_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_exec_ready"}, 32'(cmd_ready), 32'd0);
      @(posedge clk); #1;
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_rsp_data"}, rsp_data, exp_data);
      chk({tag, "_rsp_err"}, 32'(rsp_err), 32'(exp_err));
      if (rsp_ready) begin
         @(posedge clk); #1;
         chk({tag, "_idle_valid"}, 32'(rsp_valid), 32'd0);
         chk({tag, "_idle_ready"}, 32'(cmd_ready), 32'd1);
      end
   endtask

   task automatic dbg(input string tag, input logic [3:0] addr, input logic [31:0] exp);
      dbg_addr = addr;
      #1;
      chk(tag, dbg_data, exp);
   endtask

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_ld = 1'b0; cmd_bsel = 1'b0;
      cmd_rd = '0; cmd_rn = '0; cmd_rm = '0; cmd_data = '0; rsp_ready = 1'b1; dbg_addr = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      chk("rst_valid", 32'(rsp_valid), 32'd0);
      chk("rst_alu_a", alu_a, 32'd0);
      for (int i = 0; i < 16; i++) dbg("rst_dbg", 4'(i), 32'd0);
      @(posedge clk); #1;

      issue("ld_r1", 4'd0, 1'b1, 1'b0, 4'd1, 4'd0, 4'd0, 32'd5, 32'd5, 1'b0);
      issue("ld_r2", 4'd0, 1'b1, 1'b0, 4'd2, 4'd0, 4'd0, 32'd3, 32'd3, 1'b0);
      issue("sub", 4'd1, 1'b0, 1'b0, 4'd3, 4'd1, 4'd2, 32'd0, 32'd2, 1'b0);
      dbg("sub_dbg_r3", 4'd3, 32'd2);

      issue("ld_r1b", 4'd0, 1'b1, 1'b0, 4'd1, 4'd0, 4'd0, 32'd1, 32'd1, 1'b0);
      issue("ld_r2b", 4'd0, 1'b1, 1'b0, 4'd2, 4'd0, 4'd0, 32'd4, 32'd4, 1'b0);
      issue("shl", 4'd8, 1'b0, 1'b0, 4'd3, 4'd1, 4'd2, 32'd0, 32'h10, 1'b0);
      dbg("shl_dbg_r3", 4'd3, 32'h10);
      issue("not_r0", 4'd11, 1'b0, 1'b0, 4'd6, 4'd0, 4'd0, 32'd0, 32'hFFFF_FFFF, 1'b0);
      dbg("not_dbg_r6", 4'd6, 32'hFFFF_FFFF);

      // Same register as destination and both sources; EXEC-cycle dbg still shows old value.
      issue("ld_r4", 4'd0, 1'b1, 1'b0, 4'd4, 4'd0, 4'd0, 32'd7, 32'd7, 1'b0);
      dbg_addr = 4'd4;
      cmd_op = 4'd0; cmd_ld = 1'b0; cmd_bsel = 1'b0; cmd_rd = 4'd4; cmd_rn = 4'd4; cmd_rm = 4'd4;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      chk("same_exec_dbg_old", dbg_data, 32'd7);
      @(posedge clk); #1;
      chk("same_rsp_data", rsp_data, 32'd14);
      chk("same_dbg_new", dbg_data, 32'd14);
      @(posedge clk); #1;

      issue("ld_r5", 4'd0, 1'b1, 1'b0, 4'd5, 4'd0, 4'd0, 32'h55, 32'h55, 1'b0);
      issue("bad_0101", 4'd5, 1'b0, 1'b0, 4'd5, 4'd1, 4'd2, 32'd0, 32'd0, 1'b1);
      dbg("bad_0101_r5", 4'd5, 32'h55);
      issue("bad_1111", 4'd15, 1'b0, 1'b0, 4'd5, 4'd1, 4'd2, 32'd0, 32'd0, 1'b1);
      dbg("bad_1111_r5", 4'd5, 32'h55);
      issue("bad_1100", 4'd12, 1'b0, 1'b0, 4'd5, 4'd1, 4'd2, 32'd0, 32'd0, 1'b1);

      issue("ld_r1c", 4'd0, 1'b1, 1'b0, 4'd1, 4'd0, 4'd0, 32'd5, 32'd5, 1'b0);
      issue("ld_r2c", 4'd0, 1'b1, 1'b0, 4'd2, 4'd0, 4'd0, 32'd3, 32'd3, 1'b0);
`ifdef ALU_ISSUE_IMM_EN
      issue("imm_add", 4'd0, 1'b0, 1'b1, 4'd7, 4'd1, 4'd2, 32'h100, 32'h105, 1'b0);
`else
      issue("imm_add", 4'd0, 1'b0, 1'b1, 4'd7, 4'd1, 4'd2, 32'h100, 32'h8, 1'b0);
`endif
      issue("reg_add", 4'd0, 1'b0, 1'b0, 4'd7, 4'd1, 4'd2, 32'h100, 32'h8, 1'b0);

      // Response back-pressure: outputs hold while rsp_ready is low.
      rsp_ready = 1'b0;
      issue("stall", 4'd4, 1'b0, 1'b0, 4'd8, 4'd1, 4'd2, 32'd0, 32'd6, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("stall_valid", 32'(rsp_valid), 32'd1);
         chk("stall_data", rsp_data, 32'd6);
         chk("stall_ready", 32'(cmd_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("stall_rel_valid", 32'(rsp_valid), 32'd0);
      chk("stall_rel_ready", 32'(cmd_ready), 32'd1);

      // Reset while holding a response.
      rsp_ready = 1'b0;
      issue("rst_resp", 4'd0, 1'b0, 1'b0, 4'd9, 4'd1, 4'd2, 32'd0, 32'd8, 1'b0);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("rstmid_valid", 32'(rsp_valid), 32'd0);
      chk("rstmid_alu_b", alu_b, 32'd0);
      for (int i = 0; i < 16; i++) dbg("rstmid_dbg", 4'(i), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("rstmid_ready", 32'(cmd_ready), 32'd1);
      issue("post_rst_ld", 4'd0, 1'b1, 1'b0, 4'd1, 4'd0, 4'd0, 32'h2A, 32'h2A, 1'b0);
      dbg("post_rst_r1", 4'd1, 32'h2A);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Command-side sequencer for the ARM7 ALU (`alu_k`). Accepts register-addressed ALU commands over a valid/ready handshake, reads operands from a 16×32 register file, and drives registered `opcode`/`a`/`b` into the ALU. It captures the ALU result, writes it back, and returns it on a response handshake. It sits between instruction decode and the ALU, and is the only driver of the ALU's inputs.

## Interface
Parameters:
- NREG, 16, register-file depth; fixed at 16 (4-bit register indices).
- DW, 32, datapath width; must match the ALU.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_op  in  4  ALU opcode.
- cmd_ld  in  1  load command: write cmd_data to rd and bypass the ALU.
- cmd_bsel  in  1  use cmd_data as the b operand instead of reg[rm] (only with ALU_ISSUE_IMM_EN).
- cmd_rd / cmd_rn / cmd_rm  in  4 each  destination, a-source and b-source indices.
- cmd_data  in  32  load value or immediate.
- alu_op  out  4  to ALU opcode.
- alu_a / alu_b  out  32 each  to ALU operands.
- alu_out  in  32  from ALU result; combinational from alu_op/alu_a/alu_b.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_data  out  32  result written, or 0 on error.
- rsp_err  out  1  opcode was invalid; no write-back.
- dbg_addr  in  4  debug read index.
- dbg_data  out  32  reg[dbg_addr], combinational.

## Operation
- FSM states: IDLE, EXEC, RESP.
- Reset: state IDLE, all registers 0, alu_op/alu_a/alu_b = 0, rsp_valid = 0, rsp_data = 0, rsp_err = 0.
- cmd_ready = 1 only in IDLE.
- IDLE, on cmd_valid & cmd_ready:
  - Latch cmd_op to alu_op, reg[cmd_rn] to alu_a, and reg[cmd_rm] (or cmd_data, see Configuration) to alu_b.
  - Latch rd and ld.
  - Go to EXEC.
- EXEC (one cycle):
  - If ld: reg[rd] ← latched cmd_data; rsp_data ← cmd_data; rsp_err ← 0.
  - Else if alu_op is valid (0000–0100, 0110–1011): reg[rd] ← alu_out; rsp_data ← alu_out; rsp_err ← 0.
  - Else (0101, 1100–1111): no write; rsp_data ← 0; rsp_err ← 1.
  - Set rsp_valid; go to RESP.
- RESP: hold rsp_valid/rsp_data/rsp_err stable until rsp_ready. On rsp_valid & rsp_ready: rsp_valid ← 0; go to IDLE.
- alu_op/alu_a/alu_b hold their values after EXEC until the next accept.
- Operands pass to the ALU unmodified (shift amount = full 32-bit b). Register indices wrap naturally at 4 bits; no register is hardwired to zero.
- Same-register cases (rd == rn == rm) are legal: operands are read at accept, write happens in EXEC.
- dbg_data reads the registered file: on the EXEC cycle writing dbg_addr it shows the old value, and the new value from the next cycle.

## Timing
- Accept→write-back: 1 cycle (EXEC edge).
- Accept→rsp_valid high: 1 cycle.
- Best throughput: one command per 3 cycles (IDLE, EXEC, RESP with rsp_ready held 1).
- Back-to-back dependency is safe: the next accept occurs after write-back.
- Asynchronous reset at any point (including EXEC or RESP) immediately returns to IDLE, clears rsp_valid and all registers, and drops the in-flight command without a response.
- After reset deassertion, cmd_ready = 1 on the first clock.

## Configuration
- ALU_ISSUE_IMM_EN defined: when cmd_bsel = 1 at accept, alu_b ← cmd_data instead of reg[cmd_rm].
- ALU_ISSUE_IMM_EN undefined: cmd_bsel is ignored, and alu_b always comes from reg[cmd_rm].
- Ports are identical in both builds.

## Test plan
- Reset, then dbg sweep of 0–15 → all read 0. cmd_ready = 1; rsp_valid = 0.
- ld r1 = 0x0000_0005, ld r2 = 0x0000_0003, then op 0001 with rd = r3, rn = r1, rm = r2 → rsp_data = 0x2, rsp_err = 0, dbg r3 = 0x2. rsp_valid rises 1 cycle after accept.
- Op 1000 with r1 = 1, r2 = 4 → r3 = 0x10. Op 1011 with rn = r0 = 0 → 0xFFFF_FFFF. Op 0000 with rd = rn = rm = r4 (r4 = 7) → r4 = 14.
- Op 0101 with rd = r5 → rsp_err = 1, rsp_data = 0, r5 unchanged. Op 1111 → same.
- Hold rsp_ready = 0 for 5 cycles → rsp_valid/rsp_data stable and cmd_ready = 0. Assert rsp_ready → returns to IDLE next cycle.
- IMM_EN build: op 0000 with bsel = 1, r1 = 5, cmd_data = 0x100 → 0x105. Non-IMM build, same command with r2 = 3 → 0x8.
- Assert rst during RESP → rsp_valid = 0 immediately, all registers = 0, cmd_ready = 1 after release.
